iir_out_detector: RTL

Downstream stage of the float32 biquad IIR filter. It captures each new filter output word (IEEE-754 single) on the filter's sample strobe and converts it to saturated signed fixed point. It then accumulates rectified magnitude over a window of samples and drives a hysteretic tone-present flag for the decoder control logic. The datapath is fully pipelined, so it accepts a strobe every cycle.

---
 rtl/iir_out_detector_if.sv | 34 +++
 rtl/iir_out_detector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iir_out_detector_if.sv
// rtl/iir_out_detector_if.sv - sample/result bundle between the IIR filter, the detector and its consumer
//
// Purpose: groups the sample strobe/word coming from the filter and the
// converted-sample / energy / tone results produced by the detector.
// Signals:
//   sampl_i       strobe, i_signal holds a new filter output
//   i_signal      filter output word, IEEE-754 single
//   o_fixed       converted sample, signed 16-bit fixed point
//   o_valid       one-cycle pulse, o_fixed updated
//   sat_flag      current sample clamped or non-finite
//   o_energy      last completed window sum of |o_fixed|
//   energy_valid  one-cycle pulse, o_energy updated
//   tone_det      hysteretic tone-present flag
// Modports: master = filter/consumer side, slave = detector.
interface iir_out_detector_if;
  logic        sampl_i;
  logic [31:0] i_signal;
  logic [15:0] o_fixed;
  logic        o_valid;
  logic        sat_flag;
  logic [31:0] o_energy;
  logic        energy_valid;
  logic        tone_det;

  modport master (
    output sampl_i, i_signal,
    input  o_fixed, o_valid, sat_flag, o_energy, energy_valid, tone_det
  );

  modport slave (
    input  sampl_i, i_signal,
    output o_fixed, o_valid, sat_flag, o_energy, energy_valid, tone_det
  );
endinterface

// File: rtl/iir_out_detector.sv
// rtl/iir_out_detector.sv - float32 to fixed-point converter with windowed energy and hysteretic tone flag
//
// Purpose: captures each filter output on its strobe, converts IEEE-754
// single to saturated signed fixed point (3-stage pipeline), sums |sample|
// over WIN-sample windows and drives a hysteretic tone-present flag.
// Ports:
//   clk      system clock
//   reset_l  asynchronous active-low reset
//   start    run enable; low clears window state and tone_det
//   thr_on   energy threshold that sets tone_det
//   thr_off  energy threshold below which tone_det clears
//   bus      iir_out_detector_if.slave (sample in, results out)
module iir_out_detector #(
  parameter int FRAC_BITS = 8,
  parameter int WIN       = 64,
  parameter int OUT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 start,
  input  logic [31:0]          thr_on,
  input  logic [31:0]          thr_off,
  iir_out_detector_if.slave    bus
);

  localparam int CNT_W = $clog2(WIN);
  localparam int ACC_W = 17 + CNT_W;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_next;
  logic   acc_en;
  logic   win_clr;

  // S1
  logic        s1_valid;
  logic [31:0] s1_data;

  // S2
  logic        s2_valid;
  logic        s2_sign;
  logic [23:0] s2_mant;
  logic [9:0]  s2_p;      // two's complement, bit 9 is the sign
  logic        s2_zero;
  logic        s2_nan;
  logic        s2_inf;

  // S3
  logic             o_valid_q;
  logic [OUT_W-1:0] o_fixed_q;
  logic             sat_q;
  logic [OUT_W-1:0] fix_val;
  logic [OUT_W-1:0] fix_mag;
  logic             fix_sat;
  logic [4:0]       shamt;

  // Energy
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_next;
  logic [16:0]      fx_abs;
  logic [31:0]      energy_q;
  logic             energy_valid_q;
  logic             tone_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = start ? RUN : IDLE;
  end

  // Dropping start clears the window on the next edge and overrides a
  // window-completing o_valid in the same cycle.
  always_comb begin
    win_clr = !start;
    acc_en  = (state == RUN) && start && o_valid_q;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= start && bus.sampl_i;
      if (start && bus.sampl_i) s1_data <= bus.i_signal;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mant  <= '0;
      s2_p     <= '0;
      s2_zero  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_data[31];
        s2_mant <= {1'b1, s1_data[22:0]};
        s2_p    <= {2'b00, s1_data[30:23]} - 10'd127 + 10'(FRAC_BITS);
        s2_zero <= (s1_data[30:23] == 8'h00);
        s2_nan  <= (s1_data[30:23] == 8'hFF) && (s1_data[22:0] != 23'd0);
        s2_inf  <= (s1_data[30:23] == 8'hFF) && (s1_data[22:0] == 23'd0);
      end
    end
  end

  // p >= 15 means |value| >= 32768 after scaling, so it clamps.
  always_comb begin
    fix_val = '0;
    fix_mag = '0;
    fix_sat = 1'b0;
    shamt   = '0;
    if (s2_zero) begin
      fix_val = '0;
    end else if (s2_nan) begin
      fix_sat = 1'b1;
    end else if (s2_inf || (!s2_p[9] && s2_p >= 10'd15)) begin
      fix_sat = 1'b1;
      fix_val = s2_sign ? 16'h8000 : 16'h7FFF;
    end else if (!s2_p[9]) begin
      shamt   = 5'd23 - s2_p[4:0];
      fix_mag = 16'(s2_mant >> shamt);
      fix_val = s2_sign ? (16'd0 - fix_mag) : fix_mag;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      o_valid_q <= 1'b0;
      o_fixed_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      o_valid_q <= s2_valid;
      if (s2_valid) begin
        o_fixed_q <= fix_val;
        sat_q     <= fix_sat;
      end
    end
  end

  // |-32768| needs the 17th bit.
  always_comb begin
    fx_abs   = o_fixed_q[15] ? (17'd0 - {1'b1, o_fixed_q}) : {1'b0, o_fixed_q};
    sum_next = acc + ACC_W'(fx_abs);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt            <= '0;
      acc            <= '0;
      energy_q       <= '0;
      energy_valid_q <= 1'b0;
      tone_q         <= 1'b0;
    end else begin
      energy_valid_q <= 1'b0;
      if (win_clr) begin
        cnt    <= '0;
        acc    <= '0;
        tone_q <= 1'b0;
      end else if (acc_en) begin
        if (cnt == CNT_W'(WIN - 1)) begin
          cnt            <= '0;
          acc            <= '0;
          energy_q       <= 32'(sum_next);
          energy_valid_q <= 1'b1;
          if (!tone_q && (32'(sum_next) >= thr_on))
            tone_q <= 1'b1;
          else if (tone_q && (32'(sum_next) < thr_off))
            tone_q <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
          acc <= sum_next;
        end
      end
    end
  end

  assign bus.o_fixed      = o_fixed_q;
  assign bus.o_valid      = o_valid_q;
  assign bus.sat_flag     = sat_q;
  assign bus.o_energy     = energy_q;
  assign bus.energy_valid = energy_valid_q;
  assign bus.tone_det     = tone_q;

endmodule
